// File: rtl/trolley_motor_pkg.sv
// Shared constants for the trolley motor controller: register map, direction codes, channel states.
// Pure declarations; no logic, no latency.
package trolley_motor_pkg;

  localparam logic [3:0] ADDR_CTRL    = 4'd0;
  localparam logic [3:0] ADDR_STATUS  = 4'd1;
  localparam logic [3:0] ADDR_TARGET0 = 4'd2;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_CLR_BIT   = 1;
  localparam int CTRL_IRQEN_BIT = 2;

  // {dir_b, dir_a}
  localparam logic [1:0] DIR_COAST = 2'b00;
  localparam logic [1:0] DIR_FWD   = 2'b01;
  localparam logic [1:0] DIR_REV   = 2'b10;
  localparam logic [1:0] DIR_BRAKE = 2'b11;

  typedef enum logic [2:0] {
    CH_COAST,
    CH_RUN,
    CH_RAMP_DOWN,
    CH_DEAD,
    CH_BRAKE
  } ch_state_t;

  function automatic logic [1:0] req_dir(input logic reverse);
    return reverse ? DIR_REV : DIR_FWD;
  endfunction

endpackage

// File: rtl/trolley_motor_ctrl_if.sv
// Avalon-MM slave bus bundle for the trolley motor controller.
// Read data is registered one clock after avs_read; no wait states, no backpressure.
interface trolley_motor_ctrl_if;
  logic [3:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address,
    output avs_write,
    output avs_writedata,
    output avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_write,
    input  avs_writedata,
    input  avs_read,
    output avs_readdata
  );
endinterface

// File: rtl/trolley_motor_channel.sv
// One motor channel: state machine, slew-limited duty, reversal dead time and registered PWM compare.
// Outputs react one clock after their inputs change; no backpressure.
module trolley_motor_channel
  import trolley_motor_pkg::*;
#(
  parameter int          PWM_W     = 8,
  parameter int unsigned RAMP_STEP = 1,
  parameter int unsigned DEAD_CYC  = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_estop,
  input  logic             i_tick,
  input  logic [PWM_W-1:0] i_cnt,
  input  logic [PWM_W+1:0] i_target,
  output logic [2:0]       o_motor,
  output logic [PWM_W+1:0] o_duty_rd,
  output logic             o_at_target
);

  localparam int DC_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [DC_W-1:0]  DEAD_LD = DC_W'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);
  localparam logic [PWM_W-1:0] STEP_D  = PWM_W'(RAMP_STEP);

  ch_state_t        r_state;
  logic [PWM_W-1:0] r_duty;
  logic [1:0]       r_dir;
  logic [DC_W-1:0]  r_dead;
  logic             r_pwm;

  ch_state_t        w_state_nxt;
  logic [PWM_W-1:0] w_duty_nxt;
  logic [1:0]       w_dir_nxt;
  logic [DC_W-1:0]  w_dead_nxt;

  logic [PWM_W-1:0] w_mag;
  logic [1:0]       w_req_dir;
  logic             w_brake;
  logic [PWM_W-1:0] w_ramp_tgt;
  logic [PWM_W-1:0] w_stepped;

  assign w_mag      = i_target[PWM_W-1:0];
  assign w_req_dir  = req_dir(i_target[PWM_W]);
  assign w_brake    = i_target[PWM_W+1];
  assign w_ramp_tgt = (r_state == CH_RAMP_DOWN) ? '0 : w_mag;

  // One slew step toward the ramp target, landing exactly on it when within one step.
  always_comb begin
    w_stepped = r_duty;
    if (r_duty < w_ramp_tgt) begin
      if (32'(w_ramp_tgt - r_duty) <= RAMP_STEP) w_stepped = w_ramp_tgt;
      else                                       w_stepped = r_duty + STEP_D;
    end else if (r_duty > w_ramp_tgt) begin
      if (32'(r_duty - w_ramp_tgt) <= RAMP_STEP) w_stepped = w_ramp_tgt;
      else                                       w_stepped = r_duty - STEP_D;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_dir_nxt   = r_dir;
    w_dead_nxt  = r_dead;
    // Emergency stop outranks disable, which outranks the per-channel brake bit.
    if (i_estop || (i_enable && w_brake)) begin
      w_state_nxt = CH_BRAKE;
      w_duty_nxt  = '0;
      w_dir_nxt   = DIR_BRAKE;
    end else if (!i_enable) begin
      w_state_nxt = CH_COAST;
      w_duty_nxt  = '0;
      w_dir_nxt   = DIR_COAST;
    end else begin
      unique case (r_state)
        CH_COAST: begin
          w_duty_nxt = '0;
          w_dir_nxt  = DIR_COAST;
          if (w_mag != '0) begin
            w_state_nxt = CH_RUN;
            w_dir_nxt   = w_req_dir;
          end
        end
        CH_RUN: begin
          if (w_req_dir != r_dir) begin
            w_state_nxt = CH_RAMP_DOWN;
          end else if (w_mag == '0 && r_duty == '0) begin
            w_state_nxt = CH_COAST;
            w_dir_nxt   = DIR_COAST;
          end else if (i_tick) begin
            w_duty_nxt = w_stepped;
          end
        end
        CH_RAMP_DOWN: begin
          if (r_duty == '0) begin
            w_state_nxt = CH_DEAD;
            w_dir_nxt   = DIR_COAST;
            w_dead_nxt  = DEAD_LD;
          end else if (i_tick) begin
            w_duty_nxt = w_stepped;
          end
        end
        CH_DEAD: begin
          w_dir_nxt = DIR_COAST;
          if (r_dead == '0) begin
            w_state_nxt = CH_RUN;
            w_dir_nxt   = w_req_dir;
          end else begin
            w_dead_nxt = r_dead - DC_W'(1);
          end
        end
        CH_BRAKE: begin
          w_state_nxt = CH_COAST;
          w_duty_nxt  = '0;
          w_dir_nxt   = DIR_COAST;
        end
        default: begin
          w_state_nxt = CH_COAST;
          w_duty_nxt  = '0;
          w_dir_nxt   = DIR_COAST;
        end
      endcase
    end
  end

  // PWM compares against the next duty so a forced stop shows up together with the direction change.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= CH_COAST;
      r_duty  <= '0;
      r_dir   <= DIR_COAST;
      r_dead  <= '0;
      r_pwm   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_duty  <= w_duty_nxt;
      r_dir   <= w_dir_nxt;
      r_dead  <= w_dead_nxt;
      r_pwm   <= (i_cnt < w_duty_nxt);
    end
  end

  assign o_motor     = {r_pwm, r_dir};
  assign o_duty_rd   = {(r_dir == DIR_BRAKE), (r_dir == DIR_REV), r_duty};
  assign o_at_target = (r_duty == w_mag) && (r_dir == w_req_dir);

endmodule

// File: rtl/trolley_motor_ctrl.sv
// Multi-channel trolley motor driver: Avalon-MM registers, shared PWM counter and ramp tick, estop latch.
// Reads return one clock after avs_read, writes take effect at their edge; no wait states.
module trolley_motor_ctrl
  import trolley_motor_pkg::*;
#(
  parameter int          N_CH      = 2,
  parameter int          PWM_W     = 8,
  parameter int unsigned RAMP_DIV  = 1024,
  parameter int unsigned RAMP_STEP = 1,
  parameter int unsigned DEAD_CYC  = 64
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  trolley_motor_ctrl_if.slave avs,
  input  logic                prox_sensor_export,
  output logic [3*N_CH-1:0]   motor_export,
  output logic                irq
);

  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'((RAMP_DIV > 0) ? RAMP_DIV - 1 : 0);
  localparam logic [3:0]       ADDR_DUTY0 = 4'(ADDR_TARGET0 + N_CH);

  logic             r_enable;
  logic             r_irq_en;
  logic             r_estop;
  logic             r_prox_s1;
  logic             r_prox_s2;
  logic             r_prox_d;
  logic [PWM_W-1:0] r_pwm_cnt;
  logic [DIV_W-1:0] r_div;
  logic [PWM_W+1:0] r_target [N_CH];
  logic [31:0]      r_readdata;

  logic             w_tick;
  logic             w_prox_rise;
  logic             w_wr_ctrl;
  logic             w_estop_clr;
  logic             w_estop_hold;
  logic [31:0]      w_rd_mux;
  logic [PWM_W+1:0] w_duty_rd [N_CH];
  logic [N_CH-1:0]  w_at_target;
  logic             w_unused_wdata;

  assign w_tick       = (r_div == DIV_LAST);
  assign w_prox_rise  = r_prox_s2 & ~r_prox_d;
  assign w_wr_ctrl    = avs.avs_write && (avs.avs_address == ADDR_CTRL);
  assign w_estop_clr  = w_wr_ctrl && avs.avs_writedata[CTRL_CLR_BIT] && !r_prox_s2;
  // Channels stay braked for as long as the latch is set, and from the edge cycle itself.
  assign w_estop_hold = r_estop | w_prox_rise;
  assign w_unused_wdata = &{1'b0, avs.avs_writedata};

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_enable   <= 1'b0;
      r_irq_en   <= 1'b0;
      r_estop    <= 1'b0;
      r_prox_s1  <= 1'b0;
      r_prox_s2  <= 1'b0;
      r_prox_d   <= 1'b0;
      r_pwm_cnt  <= '0;
      r_div      <= '0;
      r_readdata <= '0;
      for (int ch = 0; ch < N_CH; ch++) r_target[ch] <= '0;
    end else begin
      r_prox_s1 <= prox_sensor_export;
      r_prox_s2 <= r_prox_s1;
      r_prox_d  <= r_prox_s2;
      r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
      r_div     <= w_tick ? '0 : r_div + DIV_W'(1);
      if (w_wr_ctrl) begin
        r_enable <= avs.avs_writedata[CTRL_EN_BIT];
        r_irq_en <= avs.avs_writedata[CTRL_IRQEN_BIT];
      end
      if (w_prox_rise)      r_estop <= 1'b1;
      else if (w_estop_clr) r_estop <= 1'b0;
      for (int ch = 0; ch < N_CH; ch++) begin
        if (avs.avs_write && (avs.avs_address == 4'(ADDR_TARGET0 + ch)))
          r_target[ch] <= avs.avs_writedata[PWM_W+1:0];
      end
      r_readdata <= avs.avs_read ? w_rd_mux : '0;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    if (avs.avs_address == ADDR_CTRL)
      w_rd_mux = 32'({r_irq_en, 1'b0, r_enable});
    if (avs.avs_address == ADDR_STATUS)
      w_rd_mux = 32'({w_at_target, r_prox_s2, r_estop});
    for (int ch = 0; ch < N_CH; ch++) begin
      if (avs.avs_address == 4'(ADDR_TARGET0 + ch)) w_rd_mux = 32'(r_target[ch]);
      if (avs.avs_address == 4'(ADDR_DUTY0 + ch))   w_rd_mux = 32'(w_duty_rd[ch]);
    end
  end

  assign avs.avs_readdata = r_readdata;
  assign irq              = r_estop & r_irq_en;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    trolley_motor_channel #(
      .PWM_W     (PWM_W),
      .RAMP_STEP (RAMP_STEP),
      .DEAD_CYC  (DEAD_CYC)
    ) u_ch (
      .i_clk       (clk_clk),
      .i_rst_n     (reset_reset_n),
      .i_enable    (r_enable),
      .i_estop     (w_estop_hold),
      .i_tick      (w_tick),
      .i_cnt       (r_pwm_cnt),
      .i_target    (r_target[g]),
      .o_motor     (motor_export[3*g +: 3]),
      .o_duty_rd   (w_duty_rd[g]),
      .o_at_target (w_at_target[g])
    );
  end

endmodule

// File: tb/tb_trolley_motor_ctrl.sv
// Directed bench for trolley_motor_ctrl with 4 channels, 8-bit PWM, RAMP_DIV=4, DEAD_CYC=16.
`timescale 1ns/1ps
module tb_trolley_motor_ctrl;

  localparam int N_CH = 4;
  localparam int DEAD = 16;

  logic              clk;
  logic              rst_n;
  logic              prox;
  logic [3*N_CH-1:0] motor;
  logic              irq;

  trolley_motor_ctrl_if bus ();

  trolley_motor_ctrl #(
    .N_CH      (N_CH),
    .PWM_W     (8),
    .RAMP_DIV  (4),
    .RAMP_STEP (1),
    .DEAD_CYC  (DEAD)
  ) dut (
    .clk_clk            (clk),
    .reset_reset_n      (rst_n),
    .avs                (bus),
    .prox_sensor_export (prox),
    .motor_export       (motor),
    .irq                (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] rd;
  int          hi;
  int          dead_len;
  int          pwm_dead;
  bit          seen_rev;
  bit          found;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    @(negedge clk);
    bus.avs_write     = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    @(negedge clk);
    bus.avs_read    = 1'b0;
    d = bus.avs_readdata;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    prox  = 1'b0;
    bus.avs_address   = '0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = '0;
    bus.avs_read      = 1'b0;
    repeat (3) @(negedge clk);
    check_vec("rst_motor", 32'(motor), 0);
    check_vec("rst_irq", 32'(irq), 0);
    check_vec("rst_rdata", bus.avs_readdata, 0);
    rst_n = 1'b1;
    bus_rd(4'd0, rd); check_vec("rst_ctrl", rd, 0);
    bus_rd(4'd1, rd); check_vec("rst_status", rd, 0);
    bus_rd(4'd2, rd); check_vec("rst_target0", rd, 0);

    // Ramp ch0 to 128 forward, ch2 to 48 forward.
    bus_wr(4'd0, 32'h5);
    bus_wr(4'd2, 32'h080);
    bus_wr(4'd4, 32'h030);
    repeat (600) @(negedge clk);
    bus_rd(4'd6, rd); check_vec("ramp_duty0", rd, 32'h080);
    bus_rd(4'd1, rd); check_vec("ramp_at_target0", rd & 32'h4, 32'h4);
    check_vec("ramp_dir0", 32'(motor[1:0]), 32'h1);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (motor[2]) hi++;
    end
    check_vec("pwm0_high_count", 32'(hi), 128);

    // Settle at 64 forward, then reverse.
    bus_wr(4'd2, 32'h040);
    repeat (300) @(negedge clk);
    bus_rd(4'd6, rd); check_vec("down_duty0", rd, 32'h040);
    bus_wr(4'd2, 32'h140);
    dead_len = 0; pwm_dead = 0; seen_rev = 1'b0;
    for (int i = 0; i < 2000 && !seen_rev; i++) begin
      @(negedge clk);
      if (motor[1:0] == 2'b00) begin
        dead_len++;
        if (motor[2]) pwm_dead++;
      end else if (motor[1:0] == 2'b10) begin
        seen_rev = 1'b1;
      end
    end
    check_vec("rev_reached", 32'(seen_rev), 1);
    check_vec("rev_dead_len", 32'(dead_len), DEAD);
    check_vec("rev_dead_pwm", 32'(pwm_dead), 0);
    repeat (400) @(negedge clk);
    bus_rd(4'd6, rd); check_vec("rev_duty0", rd, 32'h140);

    // Brake bit on ch1 only.
    bus_wr(4'd3, 32'h200);
    check_vec("brk_ch1_before", 32'(motor[5:3]), 0);
    @(negedge clk);
    check_vec("brk_ch1_after", 32'(motor[5:3]), 32'h3);
    check_vec("brk_ch0_dir", 32'(motor[1:0]), 32'h2);
    check_vec("brk_ch2_dir", 32'(motor[7:6]), 32'h1);
    check_vec("brk_ch3", 32'(motor[11:9]), 0);
    bus_rd(4'd7, rd); check_vec("brk_duty1", rd, 32'h200);
    bus_rd(4'd8, rd); check_vec("brk_duty2", rd, 32'h030);
    bus_wr(4'd3, 32'h000);
    @(negedge clk);
    check_vec("brk_release_ch1", 32'(motor[5:3]), 0);

    // Emergency stop while ch2 is ramping up.
    bus_wr(4'd4, 32'h0F0);
    repeat (40) @(negedge clk);
    prox = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_vec("estop_not_yet", 32'(motor[7:6]), 32'h1);
    @(negedge clk);
    check_vec("estop_motor", 32'(motor), 32'h6DB);
    check_vec("estop_irq", 32'(irq), 1);
    bus_rd(4'd1, rd); check_vec("estop_status", rd & 32'h3, 32'h3);
    bus_rd(4'd4, rd); check_vec("estop_target2_kept", rd, 32'h0F0);
    bus_wr(4'd0, 32'h7);
    check_vec("clr_blocked_irq", 32'(irq), 1);
    check_vec("clr_blocked_motor", 32'(motor), 32'h6DB);
    bus_rd(4'd1, rd); check_vec("clr_blocked_latch", rd & 32'h1, 32'h1);
    prox = 1'b0;
    repeat (4) @(negedge clk);
    bus_wr(4'd0, 32'h7);
    check_vec("clr_irq", 32'(irq), 0);
    repeat (8) @(negedge clk);
    bus_rd(4'd6, rd);
    check_vec("clr_restart_low", (rd[7:0] <= 8'd4) ? 32'h1 : 32'h0, 32'h1);
    check_vec("clr_restart_dir", 32'(rd[9:8]), 32'h1);
    repeat (400) @(negedge clk);
    bus_rd(4'd6, rd); check_vec("clr_duty0", rd, 32'h140);

    // Disable while running.
    bus_wr(4'd0, 32'h4);
    @(negedge clk);
    check_vec("dis_motor", 32'(motor), 0);
    bus_rd(4'd2, rd); check_vec("dis_target0", rd, 32'h140);
    bus_rd(4'd6, rd); check_vec("dis_duty0", rd, 0);

    // Reset asserted while ch0 is in dead time.
    bus_wr(4'd2, 32'h002);
    bus_wr(4'd0, 32'h5);
    repeat (30) @(negedge clk);
    bus_wr(4'd2, 32'h102);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (motor[1:0] == 2'b00) found = 1'b1;
    end
    check_vec("dead_entered", 32'(found), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    bus.avs_address = 4'd2;
    bus.avs_read    = 1'b1;
    @(negedge clk);
    check_vec("mid_rst_motor", 32'(motor), 0);
    check_vec("mid_rst_irq", 32'(irq), 0);
    check_vec("mid_rst_rdata", bus.avs_readdata, 0);
    bus.avs_read = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus_rd(4'd0, rd); check_vec("post_rst_ctrl", rd, 0);
    bus_rd(4'd2, rd); check_vec("post_rst_target0", rd, 0);
    bus_rd(4'd4, rd); check_vec("post_rst_target2", rd, 0);
    bus_rd(4'd8, rd); check_vec("post_rst_duty2", rd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
